// File: rtl/musb_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX: one quotient bit per
// un-stalled cycle on operand magnitudes, signs applied when the result loads.
module musb_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_divs,
    input  logic        op_divu,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  counter_reg;
    logic [31:0] rem_reg, quo_reg, divisor_mag_reg, dividend_raw_reg;
    logic [31:0] quotient_reg, remainder_reg;
    logic        q_neg_reg, r_neg_reg, div0_reg;

    logic        start;
    logic [31:0] dividend_mag, divisor_mag;
    logic [32:0] shifted;
    logic        trial_ge;
    logic [31:0] trial_diff, rem_iter, quo_iter;
    logic        last_iter;

    assign start        = (op_divs | op_divu) & ~stall & ~flush;
    // Signed takes priority when both op strobes are high.
    assign dividend_mag = (op_divs && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign divisor_mag  = (op_divs && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // Restoring step: the shifted partial remainder can reach 33 bits, so the
    // compare is 33-bit while the kept difference always fits in 32.
    assign shifted    = {rem_reg, quo_reg[31]};
    assign trial_ge   = shifted >= {1'b0, divisor_mag_reg};
    assign trial_diff = shifted[31:0] - divisor_mag_reg;
    assign rem_iter   = trial_ge ? trial_diff : shifted[31:0];
    assign quo_iter   = {quo_reg[30:0], trial_ge};
    assign last_iter  = (counter_reg == 5'd0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = BUSY;
            BUSY: begin
                if (flush)                   state_next = IDLE;
                else if (!stall && last_iter) state_next = DONE;
            end
            DONE: begin
                if (flush || !stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst so every output reads zero while reset is held.
    assign busy      = rst & (((state_reg == IDLE) & start) | (state_reg == BUSY));
    assign ready     = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            counter_reg      <= 5'd0;
            rem_reg          <= 32'd0;
            quo_reg          <= 32'd0;
            divisor_mag_reg  <= 32'd0;
            dividend_raw_reg <= 32'd0;
            q_neg_reg        <= 1'b0;
            r_neg_reg        <= 1'b0;
            div0_reg         <= 1'b0;
            quotient_reg     <= 32'd0;
            remainder_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                rem_reg          <= 32'd0;
                quo_reg          <= dividend_mag;
                divisor_mag_reg  <= divisor_mag;
                dividend_raw_reg <= dividend;
                q_neg_reg        <= op_divs & (dividend[31] ^ divisor[31]);
                r_neg_reg        <= op_divs & dividend[31];
                div0_reg         <= (divisor == 32'd0);
                counter_reg      <= 5'(DIV_CYCLES - 1);
            end
            if (state_reg == BUSY && !flush && !stall) begin
                rem_reg <= rem_iter;
                quo_reg <= quo_iter;
                if (!last_iter) begin
                    counter_reg <= counter_reg - 5'd1;
                end else if (div0_reg) begin
                    quotient_reg  <= 32'hFFFF_FFFF;
                    remainder_reg <= dividend_raw_reg;
                end else begin
                    quotient_reg  <= q_neg_reg ? (~quo_iter + 32'd1) : quo_iter;
                    remainder_reg <= r_neg_reg ? (~rem_iter + 32'd1) : rem_iter;
                end
            end
        end
    end

endmodule

// File: tb/tb_musb_div_unit.sv
// Directed bench for musb_div_unit: a table of divides plus stall, flush and
// asynchronous-reset sequences.
module tb_musb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_divs = 1'b0;
    logic        op_divu = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        busy, ready;
    logic [31:0] quotient, remainder;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        s;
        logic        u;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[12];

    musb_div_unit #(.DIV_CYCLES(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (op_divs),
        .op_divu   (op_divu),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall     (stall),
        .flush     (flush),
        .busy      (busy),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic u, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        op_divs  = s;
        op_divu  = u;
        dividend = a;
        divisor  = b;
    endtask

    // Op is already presented this cycle; count busy cycles up to ready.
    task automatic measure(input string name, input logic [31:0] eq, input logic [31:0] er);
        int busy_cnt = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " ready"}, {31'd0, seen}, 32'd1);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'd33);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        $display("%s: q=0x%08h r=0x%08h busy_cycles=%0d", name, quotient, remainder, busy_cnt);
        @(posedge clk);
        #1;
        op_divs = 1'b0;
        op_divu = 1'b0;
        @(negedge clk);
        check({name, " ready drop"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, ready_cnt, extra;
        bit done;

        vecs[0]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4]  = '{1'b0, 1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[9]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[10] = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[11] = '{1'b0, 1'b1, 32'd0,          32'd5,          32'd0,          32'd0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].s, vecs[i].u, vecs[i].a, vecs[i].b);
            measure($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
        end

        // DIVU 1000/10: stall cycles 10..13 (BUSY) and three DONE cycles
        drive(1'b0, 1'b1, 32'd1000, 32'd10);
        busy_cnt = 0;
        ready_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ready) begin
                ready_cnt++;
                check("stall done quotient", quotient, 32'd100);
            end
            if (ready && !stall) done = 1'b1;
            @(posedge clk);
            #1;
            if (done) begin
                op_divu = 1'b0;
                stall = 1'b0;
            end else begin
                stall = ((c + 1) >= 10 && (c + 1) <= 13) ||
                        ((busy_cnt == 37 || ready) && ready_cnt < 3);
            end
        end
        check("stall busy cycles", 32'(busy_cnt), 32'd37);
        check("stall ready cycles", 32'(ready_cnt), 32'd4);
        check("stall remainder", remainder, 32'd0);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ready || busy) extra++;
        end
        check("stall single completion", 32'(extra), 32'd0);
        $display("stall 1000/10: q=0x%08h r=0x%08h busy_cycles=%0d ready_cycles=%0d",
                 quotient, remainder, busy_cnt, ready_cnt);

        // Flush at BUSY iteration 10 of DIVU 50/3
        drive(1'b0, 1'b1, 32'd50, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        op_divu = 1'b0;
        @(negedge clk);
        check("flush busy during", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy after", {31'd0, busy}, 32'd0);
        check("flush ready after", {31'd0, ready}, 32'd0);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) extra++;
        end
        check("flush ready never", 32'(extra), 32'd0);
        check("flush quotient kept", quotient, 32'd100);
        check("flush remainder kept", remainder, 32'd0);
        $display("flush 50/3: q=0x%08h r=0x%08h", quotient, remainder);
        drive(1'b0, 1'b1, 32'd9, 32'd3);
        measure("after flush 9/3", 32'd3, 32'd0);

        // Asynchronous reset mid-BUSY, then a fresh operation
        drive(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async rst quotient", quotient, 32'd0);
        check("async rst remainder", remainder, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst ready", {31'd0, ready}, 32'd0);
        $display("async reset mid-BUSY: q=0x%08h r=0x%08h busy=%0b ready=%0b",
                 quotient, remainder, busy, ready);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        measure("restart 100/7", 32'd14, 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/musb_div_unit.md
Name: musb_div_unit

Overview:
- Multi-cycle iterative 32-bit integer divider in the EX stage. It executes DIV (signed) and DIVU (unsigned) and produces quotient (LO) and remainder (HI).
- It feeds the hazard unit: its `busy` output drives `ex_request_stall`.
- It consumes the hazard unit's `ex_stall_unit` output, so it freezes whenever the pipeline behind EX is held.
- Radix-2 restoring algorithm on operand magnitudes, with sign fix-up at completion.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles. Fixed at 32 for 32-bit operands; any other value is out of scope.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- op_divs  input  1  signed divide requested by the instruction in EX
- op_divu  input  1  unsigned divide requested by the instruction in EX
- dividend  input  32  rs operand (already forwarded)
- divisor  input  32  rt operand (already forwarded)
- stall  input  1  `ex_stall_unit` from the hazard unit; freezes all state
- flush  input  1  exception/pipeline flush of EX; aborts the operation
- busy  output  1  to `ex_request_stall`; high while the result is not yet available
- ready  output  1  result valid; high in DONE
- quotient  output  32  LO result
- remainder  output  32  HI result

Behaviour:
- Reset (`rst`=0, async):
  - state=IDLE, counter=0.
  - `quotient`=0, `remainder`=0, `busy`=0, `ready`=0.
  - Internal operand/sign registers are cleared.
- States: IDLE, BUSY, DONE.
- `start` = (`op_divs` | `op_divu`) & ~`stall` & ~`flush`, evaluated only in IDLE. If both op inputs are high, signed wins.
- IDLE -> BUSY on `start`:
  - Latch |dividend| and |divisor|. Take the magnitude only for signed; the magnitude of 0x80000000 is 0x80000000 unsigned.
  - Latch q_neg = sign(dividend) ^ sign(divisor) and r_neg = sign(dividend), both for signed only.
  - Latch div0 = (divisor==0) and the raw dividend.
  - Partial remainder = 0, counter = 31.
- BUSY, one iteration per un-stalled cycle:
  - Shift {rem,quo} left by 1 and compute trial = rem - |divisor| (33-bit).
  - If trial is non-negative, rem = trial and set the quotient LSB to 1; otherwise keep rem and set the quotient LSB to 0.
  - The iteration with counter==0 is the 32nd; the FSM then moves to DONE.
  - On that edge the outputs load:
    - `quotient` = q_neg ? -q : q
    - `remainder` = r_neg ? -r : r
    - If div0: `quotient`=0xFFFFFFFF and `remainder`=raw dividend, for both DIV and DIVU.
- DONE: `ready`=1, `busy`=0.
  - Stays in DONE while `stall`=1.
  - Goes to IDLE on the first cycle with `stall`=0; the EX instruction advances on that edge.
  - `start` is not evaluated in DONE, so the same instruction never restarts.
- `busy` (combinational) = (IDLE & `start`) | BUSY. It is asserted in the very cycle the divide enters EX.
- Latency: the start cycle plus 32 BUSY cycles gives 33 cycles with `busy`=1, then `ready` in the next cycle (absent stalls).
- `stall`=1 in any state: no state, counter or output change. Each stalled cycle adds one cycle of latency.
- `flush`=1 in BUSY or DONE: go to IDLE next edge, `ready`=0. `quotient` and `remainder` keep their prior values. `flush` has priority over `stall`.
- `quotient` and `remainder` hold their value until the next completion. They change only on the BUSY->DONE edge.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives `quotient`=0x80000000, `remainder`=0. No trap is raised.
- Reset mid-operation aborts immediately with the reset values above.

Test Plan:
- DIVU 100/7, no stall -> `busy` high for exactly 33 cycles from op assertion; `ready` next cycle; `quotient`=14, `remainder`=2.
- DIV -7/2 (0xFFFFFFF9, 2) -> `quotient`=0xFFFFFFFD (-3), `remainder`=0xFFFFFFFF (-1). DIV 7/-2 -> `quotient`=-3, `remainder`=1.
- DIV 0x80000000/0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0. DIVU 5/0 -> `quotient`=0xFFFFFFFF, `remainder`=5.
- DIVU 1000/10 with `stall` pulsed for 4 cycles mid-BUSY and 3 cycles in DONE -> `busy` lasts 37 cycles; `ready` holds through the DONE stall; `quotient`=100; exactly one completion.
- `flush` asserted at BUSY iteration 10 -> IDLE next cycle, `busy`=0, `ready` never asserts, prior `quotient`/`remainder` unchanged. A new DIVU 9/3 then gives 3 and 0.
- `rst` deasserted-to-asserted (low) asynchronously mid-BUSY -> all outputs 0 immediately; after release, op high -> a fresh 33-cycle operation.
